// File: rtl/c_bit_expand_v5_0.sv
// Serial-to-parallel bit expander with per-bit output inversion and a
// double-buffered output stage: a finished word can wait on Q while the next fills.
module c_bit_expand_v5_0 #(
    parameter int              C_OUTPUTS         = 8,
    parameter logic [255:0]    C_OUTPUT_INV_MASK = "",
    parameter int              C_MSB_FIRST       = 0,
    parameter int              C_HAS_CE          = 0
) (
    input  logic                 CLK,
    input  logic                 SCLR,
    input  logic                 CE,
    input  logic                 D,
    input  logic                 ND,
    output logic                 RFD,
    output logic [C_OUTPUTS-1:0] Q,
    output logic                 RDY,
    input  logic                 ACK,
    output logic [5:0]           CNT,
    output logic                 OVF
);

    // Rightmost mask character sits in the lowest byte, so byte k drives bit k.
    function automatic logic [31:0] f_mask(input logic [255:0] s);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 32; k++) m[k] = (s[8*k +: 8] == 8'h31);
        return m;
    endfunction

    function automatic logic f_mask_ok(input logic [255:0] s);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 32; k++)
            if (!(s[8*k +: 8] inside {8'h00, 8'h30, 8'h31})) ok = 1'b0;
        return ok;
    endfunction

    localparam logic [31:0]          MASK_ALL = f_mask(C_OUTPUT_INV_MASK);
    localparam logic [C_OUTPUTS-1:0] MASK     = MASK_ALL[C_OUTPUTS-1:0];
    localparam logic [5:0]           CNT_LAST = 6'(C_OUTPUTS - 1);
    localparam logic [5:0]           CNT_FULL = 6'(C_OUTPUTS);

    if (!f_mask_ok(C_OUTPUT_INV_MASK) || C_OUTPUTS < 2 || C_OUTPUTS > 32) begin : g_param_err
        $fatal(1, "c_bit_expand_v5_0: illegal C_OUTPUTS or C_OUTPUT_INV_MASK");
    end

    typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                 r_state;
    logic [C_OUTPUTS-1:0]   r_a;
    logic [C_OUTPUTS-1:0]   r_q;
    logic                   r_rdy;
    logic [5:0]             r_cnt;
    logic                   r_ovf;

    logic                   w_ce;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_out_free;
    logic [5:0]             w_pos;
    logic [C_OUTPUTS-1:0]   w_a_next;
    logic [C_OUTPUTS-1:0]   w_word;

    assign w_ce       = (C_HAS_CE != 0) ? CE : 1'b1;
    assign w_accept   = w_ce && ND && (r_state == ST_FILL);
    assign w_last     = w_accept && (r_cnt == CNT_LAST);
    assign w_out_free = !r_rdy || ACK;
    assign w_pos      = (C_MSB_FIRST != 0) ? (CNT_LAST - r_cnt) : r_cnt;

    always_comb begin
        w_a_next = r_a;
        for (int i = 0; i < C_OUTPUTS; i++)
            if (w_accept && (w_pos == 6'(i))) w_a_next[i] = D;
    end

    // The incoming last bit is folded in here so a completed word reaches Q in one edge.
    assign w_word = w_a_next ^ MASK;

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            r_state <= ST_FILL;
            r_a     <= '0;
            r_q     <= '0;
            r_rdy   <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_ce) begin
            r_ovf <= ND && (r_state == ST_FULL);
            unique case (r_state)
                ST_FILL: begin
                    if (r_rdy && ACK) r_rdy <= 1'b0;
                    if (w_accept) begin
                        r_a <= w_a_next;
                        if (w_last) begin
                            if (w_out_free) begin
                                r_q   <= w_word;
                                r_rdy <= 1'b1;
                                r_cnt <= '0;
                            end else begin
                                r_cnt   <= CNT_FULL;
                                r_state <= ST_FULL;
                            end
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (ACK) begin
                        r_q     <= r_a ^ MASK;
                        r_rdy   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end else begin
            r_ovf <= 1'b0;
        end
    end

    assign RFD = (r_state == ST_FILL) && !SCLR;
    assign Q   = r_q;
    assign RDY = r_rdy;
    assign CNT = r_cnt;
    assign OVF = r_ovf;

endmodule

// File: tb/tb_c_bit_expand_v5_0.sv
// Directed bench for c_bit_expand_v5_0: three instances (LSB-first, MSB-first,
// masked) share one stimulus stream; expected words are hand-computed.
module tb_c_bit_expand_v5_0;

    logic       clk_sys = 1'b0;
    logic       sclr    = 1'b1;
    logic       ce      = 1'b1;
    logic       d       = 1'b0;
    logic       nd      = 1'b0;
    logic       ack     = 1'b0;

    logic       rfd0, rdy0, ovf0;
    logic [7:0] q0;
    logic [5:0] cnt0;
    logic       rfd1, rdy1, ovf1;
    logic [7:0] q1;
    logic [5:0] cnt1;
    logic       rfd2, rdy2, ovf2;
    logic [7:0] q2;
    logic [5:0] cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_sys = ~clk_sys;

    c_bit_expand_v5_0 #(.C_OUTPUTS(8), .C_OUTPUT_INV_MASK("00000000"), .C_MSB_FIRST(0), .C_HAS_CE(1)) u_lsb (
        .CLK(clk_sys), .SCLR(sclr), .CE(ce), .D(d), .ND(nd), .RFD(rfd0),
        .Q(q0), .RDY(rdy0), .ACK(ack), .CNT(cnt0), .OVF(ovf0));

    c_bit_expand_v5_0 #(.C_OUTPUTS(8), .C_OUTPUT_INV_MASK(""), .C_MSB_FIRST(1), .C_HAS_CE(1)) u_msb (
        .CLK(clk_sys), .SCLR(sclr), .CE(ce), .D(d), .ND(nd), .RFD(rfd1),
        .Q(q1), .RDY(rdy1), .ACK(ack), .CNT(cnt1), .OVF(ovf1));

    c_bit_expand_v5_0 #(.C_OUTPUTS(8), .C_OUTPUT_INV_MASK("00001111"), .C_MSB_FIRST(0), .C_HAS_CE(1)) u_inv (
        .CLK(clk_sys), .SCLR(sclr), .CE(ce), .D(d), .ND(nd), .RFD(rfd2),
        .Q(q2), .RDY(rdy2), .ACK(ack), .CNT(cnt2), .OVF(ovf2));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic feed_bit(input logic b);
        d  = b;
        nd = 1'b1;
        step();
        nd = 1'b0;
    endtask

    // Bits lo..hi of w, low index first.
    task automatic feed_range(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) feed_bit(w[i]);
    endtask

    initial begin
        step();
        step();
        check_val("rst_q",   32'(q0),   32'h0);
        check_val("rst_rdy", 32'(rdy0), 32'h0);
        check_val("rst_cnt", 32'(cnt0), 32'h0);
        check_val("rst_ovf", 32'(ovf0), 32'h0);
        check_val("rst_rfd", 32'(rfd0), 32'h0);
        sclr = 1'b0;
        #1;
        check_val("rfd_after_rst", 32'(rfd0), 32'h1);

        // Stream 1,0,1,1,0,0,1,0
        feed_range(8'h4D, 0, 2);
        check_val("cnt_partial", 32'(cnt0), 32'd3);
        check_val("rdy_partial", 32'(rdy0), 32'h0);
        feed_range(8'h4D, 3, 7);
        check_val("lsb_q",   32'(q0),   32'h4D);
        check_val("lsb_rdy", 32'(rdy0), 32'h1);
        check_val("lsb_cnt", 32'(cnt0), 32'h0);
        check_val("msb_q",   32'(q1),   32'hB2);
        check_val("inv_q",   32'(q2),   32'h42);

        // Backpressure: second word while the first is unacknowledged
        feed_range(8'hFF, 0, 7);
        check_val("full_rfd", 32'(rfd0), 32'h0);
        check_val("full_cnt", 32'(cnt0), 32'd8);
        check_val("full_q",   32'(q0),   32'h4D);
        check_val("full_rdy", 32'(rdy0), 32'h1);
        d  = 1'b0;
        nd = 1'b1;
        step();
        nd = 1'b0;
        check_val("ovf_pulse", 32'(ovf0), 32'h1);
        step();
        check_val("ovf_end", 32'(ovf0), 32'h0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_val("ack_full_q",   32'(q0),   32'hFF);
        check_val("ack_full_rdy", 32'(rdy0), 32'h1);
        check_val("ack_full_rfd", 32'(rfd0), 32'h1);
        check_val("ack_full_cnt", 32'(cnt0), 32'h0);
        check_val("inv_full_q",   32'(q2),   32'hF0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_val("ack2_rdy", 32'(rdy0), 32'h0);
        check_val("ack2_q",   32'(q0),   32'hFF);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_val("ack_idle_rdy", 32'(rdy0), 32'h0);

        // ACK coincides with the last bit of the next word
        feed_range(8'h4D, 0, 7);
        check_val("pre_sim_q", 32'(q0), 32'h4D);
        feed_range(8'hA5, 0, 6);
        check_val("sim_hold_rdy", 32'(rdy0), 32'h1);
        check_val("sim_hold_q",   32'(q0),   32'h4D);
        ack = 1'b1;
        feed_bit(1'b1);
        ack = 1'b0;
        check_val("sim_q",   32'(q0),   32'hA5);
        check_val("sim_rdy", 32'(rdy0), 32'h1);
        check_val("sim_rfd", 32'(rfd0), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_val("sim_drop_rdy", 32'(rdy0), 32'h0);

        // Reset mid-word
        feed_range(8'h4D, 0, 2);
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        check_val("mid_rst_cnt", 32'(cnt0), 32'h0);
        check_val("mid_rst_rdy", 32'(rdy0), 32'h0);
        check_val("mid_rst_q",   32'(q0),   32'h0);
        feed_range(8'h4D, 0, 7);
        check_val("clean_q",   32'(q0),   32'h4D);
        check_val("clean_rdy", 32'(rdy0), 32'h1);

        // Reset while CE is low
        feed_range(8'h4D, 0, 1);
        ce   = 1'b0;
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        ce   = 1'b1;
        check_val("ce0_rst_q",   32'(q0),   32'h0);
        check_val("ce0_rst_rdy", 32'(rdy0), 32'h0);
        check_val("ce0_rst_cnt", 32'(cnt0), 32'h0);

        // CE low mid-word with ND asserted
        feed_range(8'h4D, 0, 2);
        ce = 1'b0;
        d  = 1'b0;
        nd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("ce0_ovf", 32'(ovf0), 32'h0);
        end
        nd = 1'b0;
        check_val("ce0_cnt", 32'(cnt0), 32'd3);
        check_val("ce0_rfd", 32'(rfd0), 32'h1);
        ce = 1'b1;
        feed_range(8'h4D, 3, 7);
        check_val("ce_resume_q",   32'(q0),   32'h4D);
        check_val("ce_resume_rdy", 32'(rdy0), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
